// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a single 1-bit ALU slice.
// Operands are fed LSB first, one bit per clock; the slice carry is held in a
// flop between bits and the result/flags are assembled once the last bit is done.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op,
  input  logic             b_zero,
  input  logic             b_inv,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [1:0]  OP_SUM = 2'b00;
  localparam logic [1:0]  OP_AND = 2'b01;
  localparam logic [1:0]  OP_OR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic             bz_q;
  logic             bi_q;
  logic             cy_q;
  logic [CW-1:0]    cnt;

  logic             eb;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  // One ALU slice: effective B, carry chain (always computed) and selected output bit
  always_comb begin
    eb       = (bz_q ? 1'b0 : b_sh[0]) ^ bi_q;
    c_bit    = (a_sh[0] & eb) | ((a_sh[0] ^ eb) & cy_q);
    s_bit    = a_sh[0] ^ eb ^ cy_q;
    case (op_q)
      OP_SUM:  s_bit = a_sh[0] ^ eb ^ cy_q;
      OP_AND:  s_bit = a_sh[0] & eb;
      OP_OR:   s_bit = a_sh[0] | eb;
      default: s_bit = a_sh[0] ^ eb;
    endcase
    acc_next = {s_bit, acc[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Sequencer FSM with registered outputs; result/flags change only on RUN->DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      op_q      <= 2'b00;
      bz_q      <= 1'b0;
      bi_q      <= 1'b0;
      cy_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            acc   <= '0;
            op_q  <= op;
            bz_q  <= b_zero;
            bi_q  <= b_inv;
            cy_q  <= carry_in;
            cnt   <= '0;
            ready <= 1'b0;
            state <= S_RUN;
          end else begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          acc  <= acc_next;
          cy_q <= c_bit;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            state  <= S_DONE;
            ready  <= 1'b1;
            done   <= 1'b1;
            result <= acc_next;
            zero   <= (acc_next == '0);
            if (op_q == OP_SUM) begin
              carry_out <= c_bit;
              overflow  <= cy_q ^ c_bit;
            end else begin
              carry_out <= 1'b0;
              overflow  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for the bit-serial ALU sequencer (WIDTH = 4).
module tb_alu_serial_seq;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       op;
  logic             b_zero;
  logic             b_inv;
  logic             carry_in;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             done;

  int checks = 0;
  int passed = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .op        (op),
    .b_zero    (b_zero),
    .b_inv     (b_inv),
    .carry_in  (carry_in),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                        input logic bz, input logic bi, input logic ci);
    a_in = a; b_in = b; op = o; b_zero = bz; b_inv = bi; carry_in = ci;
  endtask

  // Accept one op, then count edges until done; lat=99 on timeout
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                        input logic bz, input logic bi, input logic ci, output int lat);
    set_in(a, b, o, bz, bi, ci);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_in(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (result !== 4'b0000) $display("FAIL reset_result got %b want 0000", result); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL reset_zero got %b want 1", zero); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL reset_carry got %b want 0", carry_out); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
  endtask

  task automatic test_add();
    int lat;
    set_in(4'b0011, 4'b0101, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ready !== 1'b0) $display("FAIL add_busy_ready got %b want 0", ready); else passed++;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != WIDTH) $display("FAIL add_latency got %0d want %0d", lat, WIDTH); else passed++;
    checks++; if (result !== 4'b1000) $display("FAIL add_result got %b want 1000", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL add_carry got %b want 0", carry_out); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL add_ovf got %b want 1", overflow); else passed++;
    checks++; if (zero !== 1'b0) $display("FAIL add_zero got %b want 0", zero); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL add_done_ready got %b want 1", ready); else passed++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b want 0", done); else passed++;
    checks++; if (result !== 4'b1000) $display("FAIL add_hold got %b want 1000", result); else passed++;
  endtask

  task automatic test_sub();
    int lat;
    run_op(4'b0101, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b1, lat);
    checks++; if (lat != WIDTH) $display("FAIL sub1_latency got %0d want %0d", lat, WIDTH); else passed++;
    checks++; if (result !== 4'b0010) $display("FAIL sub1_result got %b want 0010", result); else passed++;
    checks++; if (carry_out !== 1'b1) $display("FAIL sub1_carry got %b want 1", carry_out); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL sub1_ovf got %b want 0", overflow); else passed++;
    tick();
    run_op(4'b0011, 4'b0101, 2'b00, 1'b0, 1'b1, 1'b1, lat);
    checks++; if (result !== 4'b1110) $display("FAIL sub2_result got %b want 1110", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL sub2_carry got %b want 0", carry_out); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL sub2_ovf got %b want 0", overflow); else passed++;
    tick();
    // Negate B: 0 - 0011 = 1101
    run_op(4'b0000, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b1, lat);
    checks++; if (result !== 4'b1101) $display("FAIL neg_result got %b want 1101", result); else passed++;
    tick();
  endtask

  task automatic test_logic();
    int lat;
    run_op(4'b1100, 4'b1010, 2'b01, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (result !== 4'b1000) $display("FAIL and_result got %b want 1000", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL and_carry got %b want 0", carry_out); else passed++;
    tick();
    run_op(4'b1111, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, lat);
    checks++; if (result !== 4'b0000) $display("FAIL xor_result got %b want 0000", result); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL xor_zero got %b want 1", zero); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL xor_carry got %b want 0", carry_out); else passed++;
    tick();
    run_op(4'b1011, 4'b0110, 2'b10, 1'b1, 1'b1, 1'b1, lat);
    checks++; if (result !== 4'b1111) $display("FAIL ones_result got %b want 1111", result); else passed++;
    checks++; if (carry_out !== 1'b0) $display("FAIL ones_carry got %b want 0", carry_out); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL ones_ovf got %b want 0", overflow); else passed++;
    checks++; if (zero !== 1'b0) $display("FAIL ones_zero got %b want 0", zero); else passed++;
    tick();
  endtask

  task automatic test_start_ignored();
    int dcount = 0;
    set_in(4'b0010, 4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    // Change inputs during RUN; they must not be captured
    set_in(4'b1111, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3 * WIDTH; i++) begin
      tick();
      if (done === 1'b1) dcount++;
      if (i == WIDTH - 1) start = 1'b0;
    end
    checks++; if (dcount != 1) $display("FAIL ign_done_count got %0d want 1", dcount); else passed++;
    checks++; if (result !== 4'b0101) $display("FAIL ign_result got %b want 0101", result); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    set_in(4'b0110, 4'b0111, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != WIDTH) $display("FAIL b2b_lat1 got %0d want %0d", lat, WIDTH); else passed++;
    checks++; if (result !== 4'b1101) $display("FAIL b2b_result1 got %b want 1101", result); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL b2b_ovf1 got %b want 1", overflow); else passed++;
    // start still high in DONE: next op accepted on this edge
    set_in(4'b1001, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    checks++; if (ready !== 1'b0) $display("FAIL b2b_ready got %b want 0", ready); else passed++;
    lat = 99;
    for (int n = 2; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != WIDTH + 1) $display("FAIL b2b_gap got %0d want %0d", lat, WIDTH + 1); else passed++;
    checks++; if (result !== 4'b1100) $display("FAIL b2b_result2 got %b want 1100", result); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL b2b_ovf2 got %b want 0", overflow); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int dcount = 0;
    int lat;
    set_in(4'b0011, 4'b0101, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL mrst_ready got %b want 1", ready); else passed++;
    checks++; if (result !== 4'b0000) $display("FAIL mrst_result got %b want 0000", result); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL mrst_zero got %b want 1", zero); else passed++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    checks++; if (dcount != 0) $display("FAIL mrst_no_done got %0d want 0", dcount); else passed++;
    run_op(4'b0111, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat != WIDTH) $display("FAIL mrst_next_lat got %0d want %0d", lat, WIDTH); else passed++;
    checks++; if (result !== 4'b1000) $display("FAIL mrst_next_result got %b want 1000", result); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL mrst_next_ovf got %b want 1", overflow); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
